// File: rtl/wb_mem_stream_writer_if.sv
// Bus bundle for wb_mem_stream_writer: Wishbone memory master,
// Wishbone config slave and the outgoing valid/ready stream.
interface wb_mem_stream_writer_if #(
    parameter int WB_AW = 32,
    parameter int WB_DW = 32
);
    logic [WB_AW-1:0]   wbm_adr_o;
    logic [WB_DW-1:0]   wbm_dat_o;
    logic [WB_DW/8-1:0] wbm_sel_o;
    logic               wbm_we_o;
    logic               wbm_cyc_o;
    logic               wbm_stb_o;
    logic [2:0]         wbm_cti_o;
    logic [1:0]         wbm_bte_o;
    logic [WB_DW-1:0]   wbm_dat_i;
    logic               wbm_ack_i;
    logic               wbm_err_i;
    logic               wbm_rty_i;

    logic [WB_DW-1:0]   stream_m_data_o;
    logic               stream_m_valid_o;
    logic               stream_m_ready_i;

    logic [WB_AW-1:0]   wbs_adr_i;
    logic [WB_DW-1:0]   wbs_dat_i;
    logic [WB_DW/8-1:0] wbs_sel_i;
    logic               wbs_we_i;
    logic               wbs_cyc_i;
    logic               wbs_stb_i;
    logic [2:0]         wbs_cti_i;
    logic [1:0]         wbs_bte_i;
    logic [WB_DW-1:0]   wbs_dat_o;
    logic               wbs_ack_o;
    logic               wbs_err_o;
    logic               wbs_rty_o;

    modport master (
        output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o,
        output wbm_cyc_o, wbm_stb_o, wbm_cti_o, wbm_bte_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i,
        output stream_m_data_o, stream_m_valid_o,
        input  stream_m_ready_i,
        input  wbs_adr_i, wbs_dat_i, wbs_sel_i, wbs_we_i,
        input  wbs_cyc_i, wbs_stb_i, wbs_cti_i, wbs_bte_i,
        output wbs_dat_o, wbs_ack_o, wbs_err_o, wbs_rty_o
    );

    modport slave (
        input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o,
        input  wbm_cyc_o, wbm_stb_o, wbm_cti_o, wbm_bte_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i,
        input  stream_m_data_o, stream_m_valid_o,
        output stream_m_ready_i,
        output wbs_adr_i, wbs_dat_i, wbs_sel_i, wbs_we_i,
        output wbs_cyc_i, wbs_stb_i, wbs_cti_i, wbs_bte_i,
        input  wbs_dat_o, wbs_ack_o, wbs_err_o, wbs_rty_o
    );
endinterface

// File: rtl/wb_mem_stream_writer.sv
// Wishbone burst reader: fetches a memory buffer and streams it out
// through a first-word-fall-through FIFO, programmed over a config slave.
module wb_mem_stream_writer #(
    parameter int WB_AW         = 32,
    parameter int WB_DW         = 32,
    parameter int FIFO_AW       = 5,
    parameter int MAX_BURST_LEN = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    wb_mem_stream_writer_if.master io_bus
);
    localparam int WSB    = WB_DW / 8;
    localparam int WSB_SH = $clog2(WSB);
    localparam int BCW    = $clog2(MAX_BURST_LEN) + 1;
    localparam logic [FIFO_AW:0] DEPTH_W = (FIFO_AW+1)'(1 << FIFO_AW);
    localparam logic [2:0] CTI_INC = 3'b010;
    localparam logic [2:0] CTI_EOB = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

    state_t             r_state;
    logic               r_wbs_ack;
    logic [WB_DW-1:0]   r_wbs_dat;
    logic [WB_AW-1:0]   r_start_adr;
    logic [WB_DW-1:0]   r_buf_size;
    logic [WB_DW-1:0]   r_burst_size;
    logic               r_start;
    logic               r_busy;
    logic               r_error;
    logic [WB_AW-1:0]   r_adr;
    logic [WB_DW-1:0]   r_remaining;
    logic [BCW-1:0]     r_beats;
    logic               r_cyc;
    logic [2:0]         r_cti;

    logic [WB_DW-1:0]   r_mem [1 << FIFO_AW];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;

    logic               w_wbs_req;
    logic [WB_DW-1:0]   w_rd_data;
    logic [WB_DW-1:0]   w_words;
    logic [WB_DW-1:0]   w_bsz;
    logic [WB_DW-1:0]   w_len_full;
    logic [BCW-1:0]     w_len;
    logic [FIFO_AW:0]   w_free;
    logic               w_room;
    logic               w_push;
    logic               w_pop;
    logic               w_unused;

    assign w_wbs_req = io_bus.wbs_cyc_i & io_bus.wbs_stb_i & ~r_wbs_ack;
    assign w_words   = r_buf_size >> WSB_SH;
    assign w_free    = DEPTH_W - r_count;
    assign w_push    = (r_state == S_BURST) & io_bus.wbm_ack_i
                     & ~io_bus.wbm_err_i;
    assign w_pop     = io_bus.stream_m_valid_o & io_bus.stream_m_ready_i;

    always_comb begin
        w_rd_data = '0;
        unique case (io_bus.wbs_adr_i[3:2])
            2'd0: w_rd_data = WB_DW'({r_error, r_busy});
            2'd1: w_rd_data = WB_DW'(r_start_adr);
            2'd2: w_rd_data = r_buf_size;
            2'd3: w_rd_data = r_burst_size;
        endcase
    end

    // A zero or oversize burst size is clamped so the FSM cannot stall.
    always_comb begin
        w_bsz = r_burst_size;
        if (w_bsz == '0)
            w_bsz = WB_DW'(1);
        else if (w_bsz > WB_DW'(MAX_BURST_LEN))
            w_bsz = WB_DW'(MAX_BURST_LEN);
        w_len_full = (r_remaining < w_bsz) ? r_remaining : w_bsz;
    end

    assign w_len  = w_len_full[BCW-1:0];
    assign w_room = WB_DW'(w_free) >= w_len_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wbs_ack    <= 1'b0;
            r_wbs_dat    <= '0;
            r_start_adr  <= '0;
            r_buf_size   <= '0;
            r_burst_size <= '0;
            r_start      <= 1'b0;
        end else begin
            r_wbs_ack <= w_wbs_req;
            r_start   <= 1'b0;
            if (w_wbs_req) begin
                if (io_bus.wbs_we_i) begin
                    unique case (io_bus.wbs_adr_i[3:2])
                        2'd0: r_start      <= io_bus.wbs_dat_i[0];
                        2'd1: r_start_adr  <= WB_AW'(io_bus.wbs_dat_i);
                        2'd2: r_buf_size   <= io_bus.wbs_dat_i;
                        2'd3: r_burst_size <= io_bus.wbs_dat_i;
                    endcase
                end else begin
                    r_wbs_dat <= w_rd_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_error     <= 1'b0;
            r_adr       <= '0;
            r_remaining <= '0;
            r_beats     <= '0;
            r_cyc       <= 1'b0;
            r_cti       <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (r_start) begin
                        r_error <= 1'b0;
                        if (w_words != '0) begin
                            r_adr       <= r_start_adr;
                            r_remaining <= w_words;
                            r_busy      <= 1'b1;
                            r_state     <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_remaining != '0 && w_room) begin
                        r_cyc   <= 1'b1;
                        r_beats <= w_len;
                        r_cti   <= (w_len == BCW'(1)) ? CTI_EOB : CTI_INC;
                        r_state <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (io_bus.wbm_err_i) begin
                        r_cyc   <= 1'b0;
                        r_cti   <= '0;
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (io_bus.wbm_ack_i) begin
                        r_adr       <= r_adr + WB_AW'(WSB);
                        r_remaining <= r_remaining - WB_DW'(1);
                        r_beats     <= r_beats - BCW'(1);
                        if (r_beats == BCW'(1)) begin
                            r_cyc <= 1'b0;
                            r_cti <= '0;
                            if (r_remaining == WB_DW'(1)) begin
                                r_busy  <= 1'b0;
                                r_state <= S_IDLE;
                            end else begin
                                r_state <= S_WAIT;
                            end
                        end else if (r_beats == BCW'(2)) begin
                            r_cti <= CTI_EOB;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= io_bus.wbm_dat_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            r_count <= r_count + (FIFO_AW+1)'(w_push)
                               - (FIFO_AW+1)'(w_pop);
        end
    end

    assign io_bus.wbm_adr_o = r_adr;
    assign io_bus.wbm_dat_o = '0;
    assign io_bus.wbm_sel_o = '1;
    assign io_bus.wbm_we_o  = 1'b0;
    assign io_bus.wbm_cyc_o = r_cyc;
    assign io_bus.wbm_stb_o = r_cyc;
    assign io_bus.wbm_cti_o = r_cti;
    assign io_bus.wbm_bte_o = 2'b00;

    assign io_bus.stream_m_data_o  = r_mem[r_rd_ptr];
    assign io_bus.stream_m_valid_o = (r_count != '0);

    assign io_bus.wbs_dat_o = r_wbs_dat;
    assign io_bus.wbs_ack_o = r_wbs_ack;
    assign io_bus.wbs_err_o = 1'b0;
    assign io_bus.wbs_rty_o = 1'b0;

    assign w_unused = ^{io_bus.wbs_sel_i, io_bus.wbs_cti_i,
                        io_bus.wbs_bte_i, io_bus.wbm_rty_i,
                        io_bus.wbs_adr_i[WB_AW-1:4],
                        io_bus.wbs_adr_i[1:0]};
endmodule

// File: tb/tb_wb_mem_stream_writer.sv
// Randomized bench for wb_mem_stream_writer: a memory/bus responder plus
// a transfer-level model of the expected address, burst and stream order.
module tb_wb_mem_stream_writer;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wb_mem_stream_writer_if #(.WB_AW(32), .WB_DW(32)) bus ();

    wb_mem_stream_writer #(
        .WB_AW(32), .WB_DW(32), .FIFO_AW(5), .MAX_BURST_LEN(128)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io_bus(bus.master)
    );

    logic [31:0] mem [128];
    logic        ack_gate = 1'b1;
    logic        err_arm  = 1'b0;
    logic        rnd_mode = 1'b0;
    int          bus_beats = 0;
    int          beats_base = 0;
    logic        w_err;

    assign w_err = bus.wbm_cyc_o & bus.wbm_stb_o & err_arm
                 & (bus_beats - beats_base == 2);
    assign bus.wbm_err_i = w_err;
    assign bus.wbm_ack_i = bus.wbm_cyc_o & bus.wbm_stb_o & ack_gate & ~w_err;
    assign bus.wbm_rty_i = 1'b0;
    assign bus.wbm_dat_i = mem[bus.wbm_adr_o[8:2]];

    always @(posedge clk)
        if (bus.wbm_cyc_o & bus.wbm_stb_o
            & (bus.wbm_ack_i | bus.wbm_err_i))
            bus_beats <= bus_beats + 1;

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Transfer model state
    logic [31:0] exp_q[$];
    int          lens_q[$];
    logic [31:0] exp_adr;
    logic [31:0] last_adr;
    int          beat_in, n_bursts, n_pop, occ, max_occ, err_cnt;
    logic        err_seen, prev_cyc;

    task automatic arm_model(input logic [31:0] sa, input int nbytes,
                             input int bsz);
        int rem;
        rem = nbytes / 4;
        exp_q.delete();
        lens_q.delete();
        beat_in = 0; n_bursts = 0; n_pop = 0;
        occ = 0; max_occ = 0; err_cnt = 0;
        err_seen = 1'b0; prev_cyc = 1'b0;
        exp_adr = sa; last_adr = '0;
        while (rem > 0) begin
            int l;
            l = (rem < bsz) ? rem : bsz;
            lens_q.push_back(l);
            rem -= l;
        end
    endtask

    initial begin
        bus.stream_m_ready_i = 1'b1;
        forever begin
            int push, pop;
            logic cs;
            @(negedge clk);
            if (rnd_mode) begin
                ack_gate = ($urandom_range(0, 3) != 0);
                bus.stream_m_ready_i = ($urandom_range(0, 9) < 3);
            end else begin
                ack_gate = 1'b1;
                bus.stream_m_ready_i = 1'b1;
            end
            #1;
            if (!rst) continue;
            push = 0; pop = 0;
            cs = bus.wbm_cyc_o & bus.wbm_stb_o;
            if (err_seen) begin
                check("cyc_drop_after_err", bus.wbm_cyc_o, 0);
                err_seen = 1'b0;
            end
            if (beat_in > 0)
                check("stb_hold", cs, 1);
            if (cs && !prev_cyc && lens_q.size() > 0)
                check("fifo_room", (DEPTH - occ) >= lens_q[0], 1);
            if (bus.stream_m_valid_o & bus.stream_m_ready_i) begin
                if (exp_q.size() == 0)
                    check("unexpected_pop", 1, 0);
                else
                    check("data", bus.stream_m_data_o, exp_q.pop_front());
                n_pop++;
                pop = 1;
            end
            if (cs & (bus.wbm_ack_i | bus.wbm_err_i)) begin
                check("adr", bus.wbm_adr_o, exp_adr);
                if (bus.wbm_err_i) begin
                    lens_q.delete();
                    beat_in = 0;
                    err_seen = 1'b1;
                    err_cnt++;
                end else begin
                    check("cti", bus.wbm_cti_o,
                          (lens_q.size() > 0 && beat_in == lens_q[0] - 1)
                          ? 3'b111 : 3'b010);
                    exp_q.push_back(mem[exp_adr[8:2]]);
                    last_adr = exp_adr;
                    exp_adr += 4;
                    push = 1;
                    beat_in++;
                    if (lens_q.size() > 0 && beat_in == lens_q[0]) begin
                        void'(lens_q.pop_front());
                        beat_in = 0;
                        n_bursts++;
                    end
                end
            end
            occ = occ + push - pop;
            if (occ > max_occ) max_occ = occ;
            prev_cyc = cs;
        end
    end

    task automatic wb_xfer(input logic we, input logic [3:0] a,
                           input logic [31:0] d, output logic [31:0] rd);
        int n;
        n = 0;
        @(negedge clk);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_adr_i = {28'b0, a};
        bus.wbs_dat_i = d;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus.wbs_ack_o && n < 20);
        check("wbs_ack_seen", bus.wbs_ack_o, 1);
        check("wbs_ack_lat", n, 1);
        rd = bus.wbs_dat_o;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        @(posedge clk); #1;
        check("wbs_ack_pulse", bus.wbs_ack_o, 0);
    endtask

    task automatic wb_write(input logic [3:0] a, input logic [31:0] d);
        logic [31:0] rd;
        wb_xfer(1'b1, a, d, rd);
    endtask

    task automatic wb_read_chk(input string tag, input logic [3:0] a,
                               input logic [31:0] exp);
        logic [31:0] rd;
        wb_xfer(1'b0, a, 32'h0, rd);
        check(tag, rd, exp);
    endtask

    task automatic start_xfer(input logic chk_lat);
        wb_write(4'h0, 32'h1);
        if (chk_lat) begin
            check("stb_lat_wait", bus.wbm_stb_o, 0);
            @(posedge clk); #1;
            check("stb_lat_first", bus.wbm_stb_o, 1);
        end
    endtask

    task automatic wait_done(input int n);
        int c;
        c = 0;
        while ((n_pop < n || bus.wbm_cyc_o) && c < 5000) begin
            @(posedge clk); #1;
            c++;
        end
        check("done_in_time", c < 5000, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic run_xfer(input logic [31:0] sa, input int nbytes,
                            input int bsz, input logic chk_lat);
        wb_write(4'h4, sa);
        wb_write(4'h8, nbytes);
        wb_write(4'hC, bsz);
        arm_model(sa, nbytes, bsz);
        start_xfer(chk_lat);
        wait_done(nbytes / 4);
        check("words", n_pop, nbytes / 4);
        check("leftover", exp_q.size(), 0);
        check("bursts", n_bursts, (nbytes / 4 + bsz - 1) / bsz);
        wb_read_chk("stat_idle", 4'h0, 32'h0);
    endtask

    initial begin
        int c, n_req;
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
        bus.wbs_adr_i = '0;   bus.wbs_dat_i = '0;   bus.wbs_sel_i = 4'hf;
        bus.wbs_cti_i = '0;   bus.wbs_bte_i = '0;
        arm_model(32'h0, 0, 1);
        repeat (3) @(posedge clk);
        #1;
        check("rst_cyc", bus.wbm_cyc_o, 0);
        check("rst_stb", bus.wbm_stb_o, 0);
        check("rst_sel", bus.wbm_sel_o, 4'hf);
        check("rst_adr", bus.wbm_adr_o, 0);
        check("rst_valid", bus.stream_m_valid_o, 0);
        check("rst_wbs_ack", bus.wbs_ack_o, 0);
        check("rst_wbs_dat", bus.wbs_dat_o, 0);
        @(negedge clk);
        rst = 1'b1;

        wb_write(4'h8, 32'd128);
        wb_write(4'hC, 32'd8);
        wb_write(4'h4, 32'h40);
        wb_read_chk("rb_buf", 4'h8, 32'd128);
        wb_read_chk("rb_bsz", 4'hC, 32'd8);
        wb_read_chk("rb_adr", 4'h4, 32'h40);

        run_xfer(32'h40, 128, 8, 1'b1);
        check("basic_last_adr", last_adr, 32'hBC);

        rnd_mode = 1'b1;
        run_xfer(32'h0, 512, 16, 1'b0);
        check("bp_max_occ", max_occ <= DEPTH, 1);
        rnd_mode = 1'b0;

        run_xfer(32'h180, 128, 5, 1'b0);
        check("bound_last_adr", last_adr, 32'h1FC);

        wb_write(4'h4, 32'h0);
        wb_write(4'h8, 32'd128);
        wb_write(4'hC, 32'd8);
        arm_model(32'h0, 128, 8);
        beats_base = bus_beats;
        err_arm = 1'b1;
        start_xfer(1'b0);
        c = 0;
        while (err_cnt == 0 && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        check("err_seen", err_cnt, 1);
        n_req = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.wbm_cyc_o) n_req++;
        end
        err_arm = 1'b0;
        check("err_no_req", n_req, 0);
        check("err_words", n_pop, 2);
        wb_read_chk("stat_err", 4'h0, 32'h2);
        arm_model(32'h0, 128, 8);
        start_xfer(1'b0);
        wb_read_chk("stat_restart", 4'h0, 32'h1);
        wait_done(32);
        check("restart_words", n_pop, 32);
        wb_read_chk("stat_after", 4'h0, 32'h0);

        wb_write(4'h4, 32'h0);
        wb_write(4'h8, 32'd512);
        wb_write(4'hC, 32'd16);
        arm_model(32'h0, 512, 16);
        beats_base = bus_beats;
        start_xfer(1'b0);
        c = 0;
        while ((bus_beats - beats_base < 3 || !bus.wbm_cyc_o) && c < 500) begin
            @(posedge clk); #1;
            c++;
        end
        check("mid_burst_reached", bus.wbm_cyc_o, 1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("mrst_cyc", bus.wbm_cyc_o, 0);
        check("mrst_stb", bus.wbm_stb_o, 0);
        check("mrst_valid", bus.stream_m_valid_o, 0);
        check("mrst_adr", bus.wbm_adr_o, 0);
        arm_model(32'h0, 0, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        wb_read_chk("mrst_buf_clr", 4'h8, 32'h0);
        run_xfer(32'h100, 64, 4, 1'b1);
        check("post_rst_last_adr", last_adr, 32'h13C);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", n_bad);
        $fatal(1);
    end
endmodule

// File: doc/wb_mem_stream_writer.md
# wb_mem_stream_writer

Wishbone DMA-style reader that fetches a buffer from memory over a Wishbone B3 burst master port and emits it as a 32-bit valid/ready stream through an internal first-word-fall-through FIFO. Software programs start address, buffer size and burst size over a Wishbone slave config port, then strobes enable. It sits between system memory and a streaming consumer such as a DAC, UART or packet engine.

## Interface
- WB_AW, 32, Wishbone address width.
- WB_DW, 32, Wishbone/stream data width; word size WSB = WB_DW/8 bytes.
- FIFO_AW, 5, FIFO depth = 2^FIFO_AW words.
- MAX_BURST_LEN, 128, maximum burst length in words; burst counter width = clog2(MAX_BURST_LEN)+1.
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  reset, asynchronous, active-low; clock clk.
- wbm_adr_o/dat_o/sel_o/we_o/cyc_o/stb_o/cti_o/bte_o  out  WB_AW/WB_DW/WB_DW/8/1/1/1/3/2  memory master; we_o=0, dat_o=0, sel_o=all ones, bte_o=00.
- wbm_dat_i/ack_i/err_i/rty_i  in  WB_DW/1/1/1  memory master responses; rty_i ignored.
- stream_m_data_o  out  WB_DW  stream data (FIFO head).
- stream_m_valid_o  out  1  FIFO not empty.
- stream_m_ready_i  in  1  consumer accepts word.
- wbs_adr_i/dat_i/sel_i/we_i/cyc_i/stb_i/cti_i/bte_i  in  WB_AW/WB_DW/WB_DW/8/1/1/1/3/2  config slave; cti/bte ignored, only adr[3:2] decoded.
- wbs_dat_o/ack_o/err_o/rty_o  out  WB_DW/1/1/1  config responses; err_o=rty_o=0.

## Operation
- Registers (byte offsets): 0x0 CTRL/STAT: write bit0=1 starts a transfer (write 0 no effect); read bit0=busy, bit1=error. 0x4 start_adr (bytes, word-aligned). 0x8 buf_size (bytes, multiple of WSB). 0xC burst_size (words, 1..MAX_BURST_LEN). All reset to 0. Writes to 0x4-0xC while busy take effect on next start.
- Start: latch adr=start_adr, remaining=buf_size/WSB, set busy, clear error. Start while busy ignored. buf_size=0: busy never sets.
- Master FSM states IDLE, WAIT, BURST. IDLE->WAIT on start. WAIT->BURST when remaining>0 and FIFO free slots >= len, len=min(burst_size, remaining). In BURST: cyc_o=stb_o=1, adr_o=current address; cti_o=010 for all but last beat, 111 on last beat (111 if len=1). Each ack: push wbm_dat_i into FIFO, adr+=WSB, remaining-=1. After last ack: cyc/stb drop; ->WAIT if remaining>0 else IDLE clearing busy.
- err_i during BURST: word discarded, bus released, error=1, busy=0, ->IDLE.
- FIFO: FWFT; data_o valid same cycle as valid_o; pop on valid&ready; simultaneous push and pop allowed, including full/empty edges. Ordering strictly ascending address.

## Timing
- Reset: all wbm outputs 0 except sel_o all ones; cyc/stb 0; stream_m_valid_o 0; wbs_ack_o 0, wbs_dat_o 0; FIFO empty; FSM IDLE.
- Config slave: ack_o one cycle after cyc&stb, one-cycle pulse, never on consecutive cycles of one access; write lands on the ack edge; read data valid with ack.
- Start-to-first-stb: 2 cycles after CTRL write ack (IDLE->WAIT->BURST) when FIFO has room.
- Master sustains one beat per cycle when ack_i held high; stb_o never drops mid-burst.
- FIFO push to valid_o: 1 cycle. Free-slot check counts in-flight burst words so FIFO never overflows.
- Reset mid-burst: cyc/stb drop immediately (asynchronous), FIFO flushed, registers cleared.

## Test plan
- Config readback: write 0x8=128, 0xC=8, 0x4=0x40; read back -> 128, 8, 0x40; each ack one cycle wide.
- Basic transfer: 512-byte random RAM, start_adr=0x40, buf 128, burst 8 -> 4 bursts of 8 with cti 010x7/111, 32 stream words equal mem[0x10..0x2F], busy then clears.
- Backpressure: ready toggled pseudo-randomly -> no loss/duplication, cyc never asserted with insufficient FIFO space, data matches.
- Boundary address: start_adr=0x180 buf 128 -> words mem[0x60..0x7F], last address 0x1FC; burst_size 5 -> bursts 5,5,...,2.
- Error: err_i on 3rd beat -> cyc drops next edge, STAT reads 0b10, no further requests; new start clears error.
- Reset mid-burst: assert rst during burst -> outputs at reset values immediately, valid_o 0, subsequent start works normally.
